// File: rtl/knight_pkg.sv
// Shared constants and types for the knight's tour command sequencer:
// cmd_proc opcodes, headings, response bytes and the sequencer state encoding.
package knight_pkg;

    localparam int NUM_MOVES = 24;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_MOVE_FF = 4'h3;

    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_POS  = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LEG1,
        ST_WAIT1,
        ST_LEG2,
        ST_WAIT2
    } tour_state_t;

    function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                           input logic [7:0] hdg,
                                           input logic [3:0] sq);
        return {op, hdg, sq};
    endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// Command handshake bundle between a command source (master) and its consumer (slave).
interface tour_cmd_if;

    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;

    modport master (output cmd, output cmd_rdy, input  clr_cmd_rdy);
    modport slave  (input  cmd, input  cmd_rdy, output clr_cmd_rdy);

endinterface

// File: rtl/tour_cmd_move_decode.sv
// Turns a one-hot knight move into two cmd_proc commands: a plain first leg
// and a fanfare second leg. Lowest set bit wins; no bit set gives two null moves.
module move_decode
    import knight_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] leg1_cmd,
    output logic [15:0] leg2_cmd
);

    logic [7:0] hdg1, hdg2;
    logic [3:0] sq1, sq2;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        hdg1 = HDG_N;
        sq1  = 4'd0;
        hdg2 = HDG_N;
        sq2  = 4'd0;
        casez (move)
            8'b???????1: begin hdg1 = HDG_N; sq1 = 4'd2; hdg2 = HDG_W; sq2 = 4'd1; end
            8'b??????10: begin hdg1 = HDG_N; sq1 = 4'd2; hdg2 = HDG_E; sq2 = 4'd1; end
            8'b?????100: begin hdg1 = HDG_W; sq1 = 4'd2; hdg2 = HDG_N; sq2 = 4'd1; end
            8'b????1000: begin hdg1 = HDG_W; sq1 = 4'd2; hdg2 = HDG_S; sq2 = 4'd1; end
            8'b???10000: begin hdg1 = HDG_S; sq1 = 4'd2; hdg2 = HDG_W; sq2 = 4'd1; end
            8'b??100000: begin hdg1 = HDG_S; sq1 = 4'd2; hdg2 = HDG_E; sq2 = 4'd1; end
            8'b?1000000: begin hdg1 = HDG_E; sq1 = 4'd2; hdg2 = HDG_S; sq2 = 4'd1; end
            8'b10000000: begin hdg1 = HDG_E; sq1 = 4'd2; hdg2 = HDG_N; sq2 = 4'd1; end
            default: ;
        endcase
    end

    assign leg1_cmd = mk_cmd(OP_MOVE,    hdg1, sq1);
    assign leg2_cmd = mk_cmd(OP_MOVE_FF, hdg2, sq2);

endmodule

// File: rtl/tour_cmd.sv
// Command mux in front of cmd_proc: passes UART commands through while idle,
// and after tour_go replays the stored knight's tour as pairs of move commands.
module tour_cmd
    import knight_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    tour_cmd_if.slave   uart,
    tour_cmd_if.master  proc,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    tour_state_t state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;
    logic [7:0]  move_q, move_d;
    logic [15:0] leg1_cmd, leg2_cmd;
    logic        last_move;

    move_decode u_move_decode (
        .move     (move_q),
        .leg1_cmd (leg1_cmd),
        .leg2_cmd (leg2_cmd)
    );

    assign last_move = (mv_indx_q == 5'(NUM_MOVES - 1));
    assign mv_indx   = mv_indx_q;

    // NOTE: state updates use <= so every flop samples pre-edge values together.
    // NOTE: only control flops live here; all are cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mv_indx_q <= '0;
            move_q    <= '0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
            move_q    <= move_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        mv_indx_d        = mv_indx_q;
        move_d           = move_q;
        proc.cmd         = leg1_cmd;
        proc.cmd_rdy     = 1'b0;
        uart.clr_cmd_rdy = 1'b0;
        resp             = RESP_POS;

        unique case (state_q)
            ST_IDLE: begin
                proc.cmd         = uart.cmd;
                proc.cmd_rdy     = uart.cmd_rdy;
                uart.clr_cmd_rdy = proc.clr_cmd_rdy;
                resp             = RESP_DONE;
                if (start_tour) begin
                    mv_indx_d = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                move_d  = move;
                state_d = ST_LEG1;
            end
            ST_LEG1: begin
                proc.cmd_rdy = 1'b1;
                if (proc.clr_cmd_rdy) state_d = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (send_resp) state_d = ST_LEG2;
            end
            ST_LEG2: begin
                proc.cmd     = leg2_cmd;
                proc.cmd_rdy = 1'b1;
                if (proc.clr_cmd_rdy) state_d = ST_WAIT2;
            end
            ST_WAIT2: begin
                proc.cmd = leg2_cmd;
                resp     = last_move ? RESP_DONE : RESP_POS;
                if (send_resp) begin
                    if (last_move) begin
                        mv_indx_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + 5'd1;
                        state_d   = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd.sv
// Scoreboard bench for tour_cmd: stimulus queues expected commands/responses,
// a monitor pops and compares them on each cmd handshake and send_resp.
module tb_tour_cmd;
    import knight_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_tour = 1'b0;
    logic       send_resp;
    logic [7:0] move;
    logic [4:0] mv_indx;
    logic [7:0] resp;

    always #5 clk = ~clk;

    tour_cmd_if uart_if ();
    tour_cmd_if proc_if ();

    tour_cmd dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_tour (start_tour),
        .move       (move),
        .mv_indx    (mv_indx),
        .uart       (uart_if.slave),
        .proc       (proc_if.master),
        .send_resp  (send_resp),
        .resp       (resp)
    );

    // tour memory with combinational read
    logic [7:0] tour_mem [NUM_MOVES];
    assign move = tour_mem[mv_indx];

    int total = 0;
    int bad   = 0;
    int n_cmd = 0;
    int n_resp = 0;

    logic [15:0] exp_cmd_q  [$];
    logic [4:0]  exp_idx_q  [$];
    logic [7:0]  exp_resp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // cmd_proc model: consumes a command, answers with send_resp three cycles later
    bit   model_en = 1'b0;
    logic man_clr  = 1'b0;
    logic model_clr = 1'b0;
    logic model_send = 1'b0;
    int   resp_wait = 0;

    assign proc_if.clr_cmd_rdy = model_en ? model_clr : man_clr;
    assign send_resp           = model_en ? model_send : 1'b0;

    initial forever begin
        @(negedge clk);
        model_clr  = 1'b0;
        model_send = 1'b0;
        if (!model_en) begin
            resp_wait = 0;
        end else if (resp_wait > 0) begin
            resp_wait--;
            if (resp_wait == 0) model_send = 1'b1;
        end else if (proc_if.cmd_rdy) begin
            model_clr = 1'b1;
            resp_wait = 3;
        end
    end

    // monitor
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && proc_if.cmd_rdy && proc_if.clr_cmd_rdy) begin
            n_cmd++;
            if (exp_cmd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_cmd: got %h expected none", proc_if.cmd);
            end else begin
                check("cmd", proc_if.cmd, exp_cmd_q.pop_front());
                check("cmd_mv_indx", mv_indx, exp_idx_q.pop_front());
            end
        end
        if (rst_n && send_resp) begin
            n_resp++;
            if (exp_resp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got %h expected none", resp);
            end else begin
                check("resp", resp, exp_resp_q.pop_front());
            end
        end
    end

    // hand-computed leg commands for each move pattern
    function automatic logic [31:0] exp_legs(input logic [7:0] m);
        casez (m)
            8'b???????1: return {16'h2002, 16'h33F1};
            8'b??????10: return {16'h2002, 16'h3BF1};
            8'b?????100: return {16'h23F2, 16'h3001};
            8'b????1000: return {16'h23F2, 16'h37F1};
            8'b???10000: return {16'h27F2, 16'h33F1};
            8'b??100000: return {16'h27F2, 16'h3BF1};
            8'b?1000000: return {16'h2BF2, 16'h37F1};
            8'b10000000: return {16'h2BF2, 16'h3001};
            default:     return {16'h2000, 16'h3000};
        endcase
    endfunction

    task automatic push_tour();
        logic [31:0] legs;
        for (int i = 0; i < NUM_MOVES; i++) begin
            legs = exp_legs(tour_mem[i]);
            exp_cmd_q.push_back(legs[31:16]);
            exp_idx_q.push_back(5'(i));
            exp_cmd_q.push_back(legs[15:0]);
            exp_idx_q.push_back(5'(i));
            exp_resp_q.push_back(8'h5A);
            exp_resp_q.push_back((i == NUM_MOVES - 1) ? 8'hA5 : 8'h5A);
        end
    endtask

    task automatic wait_cmds(input int target, input string name);
        int budget = 3000;
        while (n_cmd < target && budget > 0) begin
            @(negedge clk);
            #3;
            budget--;
        end
        check(name, n_cmd, target);
    endtask

    task automatic wait_resps(input int target, input string name);
        int budget = 3000;
        while (n_resp < target && budget > 0) begin
            @(negedge clk);
            #3;
            budget--;
        end
        check(name, n_resp, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] mem_init [NUM_MOVES] = '{8'h01, 8'h40, 8'h00, 8'h02, 8'h04, 8'h08,
                                             8'h10, 8'h20, 8'h80, 8'h0C, 8'h30, 8'h01,
                                             8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                             8'h80, 8'hC0, 8'h06, 8'h01, 8'h40, 8'h00};
        tour_mem = mem_init;
        uart_if.cmd     = 16'h1234;
        uart_if.cmd_rdy = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_mv_indx", mv_indx, 5'd0);
        check("rst_resp", resp, 8'hA5);
        check("rst_cmd_mux", proc_if.cmd, 16'h1234);
        check("rst_cmd_rdy", proc_if.cmd_rdy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // UART pass-through
        @(negedge clk);
        uart_if.cmd     = 16'h2003;
        uart_if.cmd_rdy = 1'b1;
        man_clr         = 1'b1;
        exp_cmd_q.push_back(16'h2003);
        exp_idx_q.push_back(5'd0);
        #1;
        check("uart_cmd_rdy", proc_if.cmd_rdy, 1'b1);
        check("uart_clr", uart_if.clr_cmd_rdy, 1'b1);
        check("uart_resp", resp, 8'hA5);
        @(negedge clk);
        uart_if.cmd_rdy = 1'b0;
        man_clr         = 1'b0;
        uart_if.cmd     = 16'h4567;

        // full tour
        model_en = 1'b1;
        push_tour();
        base = n_cmd;
        @(negedge clk);
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        #1;
        check("lat_load_no_rdy", proc_if.cmd_rdy, 1'b0);
        @(negedge clk);
        #1;
        check("lat_leg1_rdy", proc_if.cmd_rdy, 1'b1);
        check("lat_leg1_cmd", proc_if.cmd, 16'h2002);
        uart_if.cmd     = 16'hDEAD;
        uart_if.cmd_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #3;
            if (proc_if.clr_cmd_rdy) break;
        end
        check("tour_proc_clr_seen", proc_if.clr_cmd_rdy, 1'b1);
        check("tour_uart_clr_blocked", uart_if.clr_cmd_rdy, 1'b0);
        wait_cmds(base + 20, "wait_20_cmds");
        @(negedge clk);
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        wait_cmds(base + 40, "wait_40_cmds");
        uart_if.cmd_rdy = 1'b0;
        uart_if.cmd     = 16'h4567;
        wait_resps(2 * NUM_MOVES, "wait_all_resps");
        @(negedge clk);
        #3;
        check("tour_cmds_total", n_cmd - base, 2 * NUM_MOVES);
        check("tour_cmd_q_left", exp_cmd_q.size(), 0);
        check("tour_resp_q_left", exp_resp_q.size(), 0);
        check("end_mv_indx", mv_indx, 5'd0);
        check("end_resp", resp, 8'hA5);
        check("end_cmd_mux", proc_if.cmd, 16'h4567);
        check("end_cmd_rdy", proc_if.cmd_rdy, 1'b0);
        model_en = 1'b0;
        repeat (2) @(negedge clk);

        // abort with reset in WAIT1 of move 7
        model_en = 1'b1;
        push_tour();
        base = n_cmd;
        @(negedge clk);
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
        wait_cmds(base + 15, "wait_15_cmds");
        @(posedge clk);
        #1;
        check("abort_mv_indx", mv_indx, 5'd7);
        check("abort_wait1_resp", resp, 8'h5A);
        check("abort_wait1_no_rdy", proc_if.cmd_rdy, 1'b0);
        model_en = 1'b0;
        rst_n    = 1'b0;
        #1;
        exp_cmd_q.delete();
        exp_idx_q.delete();
        exp_resp_q.delete();
        check("abort_rst_mv_indx", mv_indx, 5'd0);
        check("abort_rst_resp", resp, 8'hA5);
        check("abort_rst_cmd_mux", proc_if.cmd, 16'h4567);
        @(negedge clk);
        rst_n = 1'b1;
        uart_if.cmd = 16'h2ABC;
        @(negedge clk);
        #1;
        check("post_abort_cmd_mux", proc_if.cmd, 16'h2ABC);
        check("post_abort_mv_indx", mv_indx, 5'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("post_abort_no_rdy", proc_if.cmd_rdy, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
